// File: rtl/spi_norflash_responder.sv
// Far-end responder for the wide-word SPI NOR-flash link: decodes a command/address
// word followed by a data word, and serves reads from or commits writes to a small register file.
module spi_norflash_responder #(
  parameter int LINEWIDE = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic                s_clk,
  input  logic                s_css,
  input  logic [LINEWIDE-1:0] s_mosi,
  output logic [LINEWIDE-1:0] s_miso,
  output logic                bad_cmd
);

  localparam logic [7:0]          CMD_READ  = 8'h01;
  localparam logic [7:0]          CMD_WRITE = 8'h02;
  localparam logic [LINEWIDE-9:0] DEPTH_V   = (LINEWIDE-8)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_d;

  logic clk_s1, clk_s2, clk_s3;
  logic css_s1, css_s2, css_s3;
  logic [LINEWIDE-1:0] mosi_s1, mosi_s2;

  logic rise, css_fall, css_rise;

  logic [LINEWIDE-1:0] mem [DEPTH];

  logic          is_write_q;
  logic          in_range_q;
  logic [AW-1:0] idx_q;

  logic          cmd_in_range;
  logic [AW-1:0] cmd_idx;
  logic          latch_cmd, do_read, do_write, set_bad, clr_miso;

  // Two-flop synchronisers; chip select idles high so its flops reset to 1.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      clk_s3  <= 1'b0;
      css_s1  <= 1'b1;
      css_s2  <= 1'b1;
      css_s3  <= 1'b1;
      mosi_s1 <= '0;
      mosi_s2 <= '0;
    end else begin
      clk_s1  <= s_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      css_s1  <= s_css;
      css_s2  <= css_s1;
      css_s3  <= css_s2;
      mosi_s1 <= s_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign rise     = clk_s2 & ~clk_s3;
  assign css_fall = ~css_s2 & css_s3;
  assign css_rise = css_s2 & ~css_s3;

  assign cmd_in_range = (mosi_s2[LINEWIDE-1:8] < DEPTH_V);
  assign cmd_idx      = mosi_s2[8+AW-1:8];

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) state <= IDLE;
    else       state <= state_d;
  end

  // Deselect is evaluated first so it overrides any coincident s_clk rise.
  always_comb begin
    state_d   = state;
    latch_cmd = 1'b0;
    do_read   = 1'b0;
    do_write  = 1'b0;
    set_bad   = 1'b0;
    clr_miso  = 1'b0;
    if (css_rise) begin
      state_d  = IDLE;
      clr_miso = 1'b1;
    end else begin
      case (state)
        IDLE: if (css_fall) state_d = CMD;
        CMD: begin
          if (rise) begin
            latch_cmd = 1'b1;
            case (mosi_s2[7:0])
              CMD_READ: begin
                do_read = 1'b1;
                state_d = DATA;
              end
              CMD_WRITE: state_d = DATA;
              default: begin
                set_bad = 1'b1;
                state_d = DONE;
              end
            endcase
          end
        end
        DATA: begin
          if (rise) begin
            do_write = is_write_q & in_range_q;
            state_d  = DONE;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      is_write_q <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
    end else if (latch_cmd) begin
      is_write_q <= (mosi_s2[7:0] == CMD_WRITE);
      in_range_q <= cmd_in_range;
      idx_q      <= cmd_idx;
    end
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      s_miso  <= '0;
      bad_cmd <= 1'b0;
    end else begin
      bad_cmd <= set_bad;
      if (clr_miso)     s_miso <= '0;
      else if (do_read) s_miso <= cmd_in_range ? mem[cmd_idx] : '0;
    end
  end

  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx_q] <= mosi_s2;
    end
  end

endmodule
